// File: rtl/sram_rd_pkg.sv
// Shared definitions for the SRAM burst stream reader: FSM encoding and
// skid buffer sizing.
package sram_rd_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int SKID_DEPTH = 2;
    localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);
    localparam int SKID_PTR_W = $clog2(SKID_DEPTH);

    function automatic logic [SKID_PTR_W-1:0] skid_ptr_inc(input logic [SKID_PTR_W-1:0] p);
        return (p == SKID_PTR_W'(SKID_DEPTH - 1)) ? '0 : p + SKID_PTR_W'(1);
    endfunction

endpackage

// File: rtl/sram_rd_skid.sv
// Two-entry FIFO that absorbs SRAM read data arriving while the stream
// consumer stalls. The head entry is always visible on o_data.
module sram_rd_skid
    import sram_rd_pkg::*;
#(
    parameter int W = 11
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic [W-1:0]          i_data,
    output logic [W-1:0]          o_data,
    output logic [SKID_CNT_W-1:0] o_count
);

    logic [W-1:0]          r_mem [SKID_DEPTH];
    logic [SKID_PTR_W-1:0] r_wr_ptr;
    logic [SKID_PTR_W-1:0] r_rd_ptr;
    logic [SKID_CNT_W-1:0] r_count;
    logic                  w_pop;

    // A pop on an empty buffer is meaningless; the producer never overfills it.
    assign w_pop = i_pop && (r_count != '0);

    // NOTE: storage is reset on purpose so the idle stream data reads as zero
    // after reset; sequential state uses non-blocking assignments throughout.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= skid_ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= skid_ptr_inc(r_rd_ptr);
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + SKID_CNT_W'(1);
                2'b01:   r_count <= r_count - SKID_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/sram_stream_reader.sv
// Reads a burst of consecutive SRAM words (address wraps at DEPTH) and
// streams them out with valid/ready handshaking and a last marker.
module sram_stream_reader
    import sram_rd_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int DEPTH = 128,
    parameter int ADDRB = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [ADDRB-1:0] i_base_addr,
    input  logic [ADDRB:0]   i_len,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_ena,
    output logic             o_rea,
    output logic [ADDRB-1:0] o_addr_o,
    input  logic [WIDTH-1:0] i_douta,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tvalid,
    input  logic             i_tready,
    output logic             o_tlast
);

    localparam int               LEN_W     = ADDRB + 1;
    localparam logic [ADDRB-1:0] ADDR_LAST = ADDRB'(DEPTH - 1);

    state_t                r_state;
    logic [ADDRB-1:0]      r_addr;
    logic [LEN_W-1:0]      r_remain;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_pend;
    logic                  r_pend_last;

    logic [WIDTH:0]        w_head;
    logic [SKID_CNT_W-1:0] w_count;
    logic                  w_tvalid;
    logic                  w_pop;
    logic                  w_head_last;
    logic [2:0]            w_occ;
    logic                  w_issue;
    logic                  w_last_issue;
    logic [ADDRB-1:0]      w_addr_next;

    assign w_tvalid    = (w_count != '0);
    assign w_pop       = w_tvalid && i_tready;
    assign w_head_last = w_head[WIDTH];

    // Words in flight after this cycle's transfer; counting the pop keeps one
    // word per cycle while never holding more than the skid can absorb.
    assign w_occ        = 3'(w_count) + 3'(r_pend) - 3'(w_pop);
    assign w_issue      = (r_state == S_READ) && (r_remain != '0) && (w_occ < 3'(SKID_DEPTH));
    assign w_last_issue = w_issue && (r_remain == LEN_W'(1));
    assign w_addr_next  = (r_addr == ADDR_LAST) ? '0 : r_addr + ADDRB'(1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_remain <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        if (i_len != '0) begin
                            r_addr   <= i_base_addr;
                            r_remain <= i_len;
                            r_busy   <= 1'b1;
                            r_state  <= S_READ;
                        end else begin
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end
                    end
                end
                S_READ: begin
                    if (w_issue) begin
                        r_addr   <= w_addr_next;
                        r_remain <= r_remain - LEN_W'(1);
                        if (w_last_issue) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_pop && w_head_last) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // SRAM data is valid the cycle after the read, so the push trails the issue.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pend      <= 1'b0;
            r_pend_last <= 1'b0;
        end else begin
            r_pend      <= w_issue;
            r_pend_last <= w_last_issue;
        end
    end

    sram_rd_skid #(
        .W (WIDTH + 1)
    ) u_skid (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (r_pend),
        .i_pop   (w_pop),
        .i_data  ({r_pend_last, i_douta}),
        .o_data  (w_head),
        .o_count (w_count)
    );

    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_ena    = w_issue;
    assign o_rea    = w_issue;
    assign o_addr_o = r_addr;
    assign o_tdata  = w_head[WIDTH-1:0];
    assign o_tvalid = w_tvalid;
    assign o_tlast  = w_tvalid && w_head_last;

endmodule

// File: tb/tb_sram_stream_reader.sv
// Scoreboard bench for sram_stream_reader: directed bursts push expected
// addresses and words into queues; a monitor pops and compares them.
module tb_sram_stream_reader;

    localparam int WIDTH = 10;
    localparam int DEPTH = 128;
    localparam int ADDRB = 7;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             last;
    } word_t;

    logic             clk;
    logic             rst_n;
    logic             i_start;
    logic [ADDRB-1:0] i_base_addr;
    logic [ADDRB:0]   i_len;
    logic             o_busy;
    logic             o_done;
    logic             o_ena;
    logic             o_rea;
    logic [ADDRB-1:0] o_addr_o;
    logic [WIDTH-1:0] i_douta;
    logic [WIDTH-1:0] o_tdata;
    logic             o_tvalid;
    logic             i_tready;
    logic             o_tlast;

    logic [WIDTH-1:0] mem [DEPTH];

    word_t            exp_q[$];
    int               addr_q[$];
    int               n_checks;
    int               n_errors;
    int               xfer_count;
    int               done_count;
    int               inflight;
    logic             prev_stall;
    logic [WIDTH-1:0] prev_data;
    logic             prev_last;
    logic             tr_mode;

    sram_stream_reader #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .ADDRB (ADDRB)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (i_start),
        .i_base_addr (i_base_addr),
        .i_len       (i_len),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_ena       (o_ena),
        .o_rea       (o_rea),
        .o_addr_o    (o_addr_o),
        .i_douta     (i_douta),
        .o_tdata     (o_tdata),
        .o_tvalid    (o_tvalid),
        .i_tready    (i_tready),
        .o_tlast     (o_tlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read SRAM model preloaded with mem[n] = n.
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = i[WIDTH-1:0];
        i_douta = '0;
    end
    always @(posedge clk) begin
        if (o_ena && o_rea) i_douta <= mem[o_addr_o];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Ready driver: constant 1 or the repeating pattern 1,0,0,1,0,1.
    initial begin
        logic pat [6];
        int   pi;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        pi = 0;
        i_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (tr_mode) begin
                i_tready = pat[pi];
                pi = (pi + 1) % 6;
            end else begin
                i_tready = 1'b1;
                pi = 0;
            end
        end
    end

    // Issues a start at a negedge and queues the expected burst; returns at
    // the negedge of the first cycle after the start was sampled.
    task automatic do_start(input int base, input int len);
        for (int k = 0; k < len; k++) begin
            word_t w;
            w.data = WIDTH'((base + k) % DEPTH);
            w.last = (k == len - 1);
            exp_q.push_back(w);
            addr_q.push_back((base + k) % DEPTH);
        end
        i_base_addr = ADDRB'(base);
        i_len       = (ADDRB + 1)'(len);
        i_start     = 1'b1;
        tick();
        i_start     = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!o_done && n < 100) begin
            tick();
            n++;
        end
        check(name, o_done, 1);
        tick();
        check({name, "_queue_empty"}, exp_q.size(), 0);
        check({name, "_addr_empty"}, addr_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            inflight   = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_hold_valid", o_tvalid, 1);
                check("stall_hold_data", o_tdata, prev_data);
                check("stall_hold_last", o_tlast, prev_last);
            end
            check("ena_matches_rea", o_rea, o_ena);
            if (o_ena && o_rea) begin
                if (addr_q.size() == 0) fail_now("unexpected_read");
                else check("read_addr", o_addr_o, addr_q.pop_front());
            end
            if (o_tvalid && i_tready) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_word");
                end else begin
                    word_t e;
                    e = exp_q.pop_front();
                    check("word_data", o_tdata, e.data);
                    check("word_last", o_tlast, e.last);
                end
                xfer_count++;
            end
            inflight = inflight + int'(o_ena && o_rea) - int'(o_tvalid && i_tready);
            if (o_ena && o_rea) check("inflight_le_2", inflight <= 2, 1);
            if (o_done) done_count++;
            prev_stall = o_tvalid && !i_tready;
            prev_data  = o_tdata;
            prev_last  = o_tlast;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int xfer_base;
        n_checks    = 0;
        n_errors    = 0;
        xfer_count  = 0;
        done_count  = 0;
        inflight    = 0;
        prev_stall  = 1'b0;
        prev_data   = '0;
        prev_last   = 1'b0;
        tr_mode     = 1'b0;
        rst_n       = 1'b0;
        i_start     = 1'b0;
        i_base_addr = '0;
        i_len       = '0;

        // Reset state
        tick();
        tick();
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_tvalid", o_tvalid, 0);
        check("rst_ena", o_ena, 0);
        check("rst_addr", o_addr_o, 0);
        check("rst_tdata", o_tdata, 0);
        rst_n = 1'b1;
        tick();

        // Basic burst: exact cycle timing and a single done pulse
        do_start(5, 4);
        check("t1_busy", o_busy, 1);
        check("t1_c1_tvalid", o_tvalid, 0);
        check("t1_c1_addr", o_addr_o, 5);
        tick();
        check("t1_c2_tvalid", o_tvalid, 0);
        tick();
        check("t1_c3_tvalid", o_tvalid, 1);
        check("t1_c3_tdata", o_tdata, 5);
        tick();
        check("t1_c4_tdata", o_tdata, 6);
        tick();
        check("t1_c5_tdata", o_tdata, 7);
        check("t1_c5_tlast", o_tlast, 0);
        tick();
        check("t1_c6_tdata", o_tdata, 8);
        check("t1_c6_tlast", o_tlast, 1);
        tick();
        check("t1_done", o_done, 1);
        check("t1_busy_low", o_busy, 0);
        tick();
        check("t1_done_pulse_end", o_done, 0);
        check("t1_ena_idle", o_ena, 0);

        // Address wrap at DEPTH-1
        do_start(126, 4);
        wait_done("t2_wrap_done");

        // Backpressure with the toggling ready pattern
        tr_mode = 1'b1;
        do_start(0, 6);
        wait_done("t3_stall_done");
        tr_mode = 1'b0;
        tick();

        // Zero-length request
        do_start(3, 0);
        check("t4_done", o_done, 1);
        check("t4_busy", o_busy, 0);
        check("t4_tvalid", o_tvalid, 0);
        check("t4_ena", o_ena, 0);
        tick();
        check("t4_done_end", o_done, 0);
        check("t4_tvalid_after", o_tvalid, 0);
        tick();

        // Reset in the middle of a burst after two words
        xfer_base = xfer_count;
        do_start(20, 8);
        tick();
        tick();
        tick();
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("t5_words_before_rst", xfer_count - xfer_base, 2);
        check("t5_busy", o_busy, 0);
        check("t5_done", o_done, 0);
        check("t5_ena", o_ena, 0);
        check("t5_rea", o_rea, 0);
        check("t5_tvalid", o_tvalid, 0);
        check("t5_tlast", o_tlast, 0);
        check("t5_addr", o_addr_o, 0);
        check("t5_tdata", o_tdata, 0);
        exp_q.delete();
        addr_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_no_stale", o_tvalid, 0);
        end
        do_start(10, 2);
        wait_done("t5_restart_done");

        // Start pulse during a burst must be ignored
        do_start(40, 5);
        i_base_addr = ADDRB'(90);
        i_len       = (ADDRB + 1)'(3);
        i_start     = 1'b1;
        tick();
        i_start     = 1'b0;
        check("t6_busy", o_busy, 1);
        wait_done("t6_done");
        tick();
        check("t6_idle_after", o_busy, 0);

        check("done_pulse_count", done_count, 6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
